// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and issue signals of the issue queue, bundled as one interface.
// The slave modport is the queue itself; the master modport is its environment.
interface issue_queue_if #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PREG_W    = 5,
    parameter int unsigned PAYLOAD_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Dispatch side (from rename)
    logic                 dispatch_valid_i;
    logic                 dispatch_ready_o;
    logic [PREG_W-1:0]    prs1_addr_i;
    logic [PREG_W-1:0]    prs2_addr_i;
    logic [PREG_W-1:0]    prd_addr_i;
    logic                 prs1_valid_i;
    logic                 prs2_valid_i;
    logic [PAYLOAD_W-1:0] payload_i;

    // Common data bus snoop
    logic                 cdb_en_i;
    logic [PREG_W-1:0]    cdb_reg_addr_i;

    // Issue side (to functional unit)
    logic                 issue_valid_o;
    logic                 issue_ready_i;
    logic [PREG_W-1:0]    issue_prs1_addr_o;
    logic [PREG_W-1:0]    issue_prs2_addr_o;
    logic [PREG_W-1:0]    issue_prd_addr_o;
    logic [PAYLOAD_W-1:0] issue_payload_o;

    logic [CNT_W-1:0]     count_o;

    modport slave (
        input  dispatch_valid_i, prs1_addr_i, prs2_addr_i, prd_addr_i,
               prs1_valid_i, prs2_valid_i, payload_i,
               cdb_en_i, cdb_reg_addr_i, issue_ready_i,
        output dispatch_ready_o, issue_valid_o, issue_prs1_addr_o,
               issue_prs2_addr_o, issue_prd_addr_o, issue_payload_o, count_o
    );

    modport master (
        output dispatch_valid_i, prs1_addr_i, prs2_addr_i, prd_addr_i,
               prs1_valid_i, prs2_valid_i, payload_i,
               cdb_en_i, cdb_reg_addr_i, issue_ready_i,
        input  dispatch_ready_o, issue_valid_o, issue_prs1_addr_o,
               issue_prs2_addr_o, issue_prd_addr_o, issue_payload_o, count_o
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue. Entry 0 is the oldest; valid entries are
// packed at 0..count-1. Issues the oldest entry whose two sources are ready.
module issue_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PREG_W    = 5,
    parameter int unsigned PAYLOAD_W = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    issue_queue_if.slave  bus
);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          DEPTH_I = int'(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic                 rdy2;
        logic [PREG_W-1:0]    prs1;
        logic [PREG_W-1:0]    prs2;
        logic [PREG_W-1:0]    prd;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           r_q [DEPTH];
    logic [CNT_W-1:0] r_count;

    entry_t           w_ext [DEPTH+1];
    entry_t           w_d   [DEPTH];
    entry_t           w_new;
    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_disp_ready;
    logic             w_disp_fire;
    logic             w_issue_fire;
    logic [CNT_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_count_d;

    // Select: lowest index whose entry is valid with both sources ready
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH_I - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].rdy1 && r_q[i].rdy2) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    assign w_disp_ready = (r_count < CNT_W'(DEPTH));
    assign w_disp_fire  = bus.dispatch_valid_i & w_disp_ready;
    assign w_issue_fire = w_sel_found & bus.issue_ready_i;
    // With an issue the queue collapses by one, so the tail slot moves down too
    assign w_wr_idx     = w_issue_fire ? (r_count - 1'b1) : r_count;

    // Incoming entry, including same-cycle CDB bypass so no wakeup is missed
    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.rdy1    = bus.prs1_valid_i || (bus.prs1_addr_i == '0) ||
                        (bus.cdb_en_i && (bus.cdb_reg_addr_i == bus.prs1_addr_i));
        w_new.rdy2    = bus.prs2_valid_i || (bus.prs2_addr_i == '0) ||
                        (bus.cdb_en_i && (bus.cdb_reg_addr_i == bus.prs2_addr_i));
        w_new.prs1    = bus.prs1_addr_i;
        w_new.prs2    = bus.prs2_addr_i;
        w_new.prd     = bus.prd_addr_i;
        w_new.payload = bus.payload_i;
    end

    // Next entry state: collapse above the issued slot, wake up, then write new entry
    always_comb begin
        w_ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH_I; i++) begin
            w_ext[i] = r_q[i];
        end
        for (int i = 0; i < DEPTH_I; i++) begin
            w_d[i] = (w_issue_fire && (i >= int'(w_sel_idx))) ? w_ext[i+1] : w_ext[i];
            if (bus.cdb_en_i && w_d[i].valid) begin
                if (w_d[i].prs1 == bus.cdb_reg_addr_i) w_d[i].rdy1 = 1'b1;
                if (w_d[i].prs2 == bus.cdb_reg_addr_i) w_d[i].rdy2 = 1'b1;
            end
            if (w_disp_fire && (int'(w_wr_idx) == i)) begin
                w_d[i] = w_new;
            end
        end
    end

    // Occupancy: +1 on dispatch only, -1 on issue only
    always_comb begin
        w_count_d = r_count;
        if (w_disp_fire && !w_issue_fire) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_disp_fire && w_issue_fire) begin
            w_count_d = r_count - 1'b1;
        end
    end

    // State register; flush behaves exactly like reset and drops same-cycle traffic
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            for (int i = 0; i < DEPTH_I; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH_I; i++) begin
                r_q[i] <= w_d[i];
            end
            r_count <= w_count_d;
        end
    end

    assign bus.dispatch_ready_o  = w_disp_ready;
    assign bus.issue_valid_o     = w_sel_found;
    assign bus.issue_prs1_addr_o = r_q[w_sel_idx].prs1;
    assign bus.issue_prs2_addr_o = r_q[w_sel_idx].prs2;
    assign bus.issue_prd_addr_o  = r_q[w_sel_idx].prd;
    assign bus.issue_payload_o   = r_q[w_sel_idx].payload;
    assign bus.count_o           = r_count;
endmodule
